alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters: port 0 (execute stage) and port 1 (address/branch-target unit). Requests are granted round-robin with a valid/ready handshake. The granted request's ALU_Control and operands are latched and driven to the ALU for one cycle. The result and branch flag are registered and returned on the owning requester's response port. Only one operation is outstanding at a time.

---
 rtl/alu_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. One operation is in flight at a time. The winning request is
// latched into the alu_* registers, the ALU result is captured one cycle later,
// and the result is held on the owner's response port until it is consumed.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    // port 0 (execute stage)
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req0_branch_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_branch,
    // port 1 (address / branch-target unit)
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic              req1_branch_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_branch,
    // shared ALU
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic              alu_branch_op,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_branch,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              busy_q, busy_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic              alu_branch_op_q, alu_branch_op_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic [WIDTH-1:0]  rsp0_result_q, rsp0_result_d;
    logic              rsp0_branch_q, rsp0_branch_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0]  rsp1_result_q, rsp1_result_d;
    logic              rsp1_branch_q, rsp1_branch_d;

    logic              grant_valid_s;
    logic              grant_s;

    // Round-robin grant, only offered in IDLE and never while reset is applied
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
        if ((state_q == IDLE) && !reset) begin
            if (req0_valid && req1_valid) begin
                grant_valid_s = 1'b1;
                grant_s       = ~last_grant_q;
            end else if (req0_valid) begin
                grant_valid_s = 1'b1;
                grant_s       = 1'b0;
            end else if (req1_valid) begin
                grant_valid_s = 1'b1;
                grant_s       = 1'b1;
            end else begin
                grant_valid_s = 1'b0;
                grant_s       = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_s       = 1'b0;
        end
    end

    assign req0_ready = grant_valid_s && (grant_s == 1'b0);
    assign req1_ready = grant_valid_s && (grant_s == 1'b1);

    // Next-state, operand latch and response capture
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        alu_ctrl_d      = alu_ctrl_q;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        alu_branch_op_d = alu_branch_op_q;
        rsp0_valid_d    = rsp0_valid_q;
        rsp0_result_d   = rsp0_result_q;
        rsp0_branch_d   = rsp0_branch_q;
        rsp1_valid_d    = rsp1_valid_q;
        rsp1_result_d   = rsp1_result_q;
        rsp1_branch_d   = rsp1_branch_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    state_d      = EXEC;
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    if (grant_s) begin
                        alu_ctrl_d      = req1_ctrl;
                        alu_a_d         = req1_a;
                        alu_b_d         = req1_b;
                        alu_branch_op_d = req1_branch_op;
                    end else begin
                        alu_ctrl_d      = req0_ctrl;
                        alu_a_d         = req0_a;
                        alu_b_d         = req0_b;
                        alu_branch_op_d = req0_branch_op;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // ALU output is valid this cycle; capture it for the owner
                state_d = RESP;
                if (owner_q) begin
                    rsp1_valid_d  = 1'b1;
                    rsp1_result_d = alu_result;
                    rsp1_branch_d = alu_branch;
                end else begin
                    rsp0_valid_d  = 1'b1;
                    rsp0_result_d = alu_result;
                    rsp0_branch_d = alu_branch;
                end
            end
            RESP: begin
                // Response is cleared back to 0 once consumed
                if (owner_q) begin
                    if (rsp1_ready) begin
                        state_d       = IDLE;
                        rsp1_valid_d  = 1'b0;
                        rsp1_result_d = {WIDTH{1'b0}};
                        rsp1_branch_d = 1'b0;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    if (rsp0_ready) begin
                        state_d       = IDLE;
                        rsp0_valid_d  = 1'b0;
                        rsp0_result_d = {WIDTH{1'b0}};
                        rsp0_branch_d = 1'b0;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            last_grant_q    <= 1'b1;
            busy_q          <= 1'b0;
            alu_ctrl_q      <= {CTRL_W{1'b0}};
            alu_a_q         <= {WIDTH{1'b0}};
            alu_b_q         <= {WIDTH{1'b0}};
            alu_branch_op_q <= 1'b0;
            rsp0_valid_q    <= 1'b0;
            rsp0_result_q   <= {WIDTH{1'b0}};
            rsp0_branch_q   <= 1'b0;
            rsp1_valid_q    <= 1'b0;
            rsp1_result_q   <= {WIDTH{1'b0}};
            rsp1_branch_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            busy_q          <= busy_d;
            alu_ctrl_q      <= alu_ctrl_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            alu_branch_op_q <= alu_branch_op_d;
            rsp0_valid_q    <= rsp0_valid_d;
            rsp0_result_q   <= rsp0_result_d;
            rsp0_branch_q   <= rsp0_branch_d;
            rsp1_valid_q    <= rsp1_valid_d;
            rsp1_result_q   <= rsp1_result_d;
            rsp1_branch_q   <= rsp1_branch_d;
        end
    end

    assign alu_ctrl      = alu_ctrl_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_branch_op = alu_branch_op_q;
    assign rsp0_valid    = rsp0_valid_q;
    assign rsp0_result   = rsp0_result_q;
    assign rsp0_branch   = rsp0_branch_q;
    assign rsp1_valid    = rsp1_valid_q;
    assign rsp1_result   = rsp1_result_q;
    assign rsp1_branch   = rsp1_branch_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU stub and per-port
// response scoreboards.
module tb_alu_arbiter;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 6;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b001000;
    localparam logic [5:0] OP_SLT = 6'b000010;
    localparam logic [5:0] OP_XOR = 6'b000100;
    localparam logic [5:0] OP_SRA = 6'b001101;
    localparam logic [5:0] OP_BNE = 6'b010001;
    localparam logic [5:0] OP_JAL = 6'b011111;

    typedef struct packed {
        logic [31:0] result;
        logic        branch;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0_valid, req0_ready, req0_branch_op;
    logic [CTRL_W-1:0] req0_ctrl;
    logic [WIDTH-1:0]  req0_a, req0_b;
    logic              rsp0_valid, rsp0_ready, rsp0_branch;
    logic [WIDTH-1:0]  rsp0_result;
    logic              req1_valid, req1_ready, req1_branch_op;
    logic [CTRL_W-1:0] req1_ctrl;
    logic [WIDTH-1:0]  req1_a, req1_b;
    logic              rsp1_valid, rsp1_ready, rsp1_branch;
    logic [WIDTH-1:0]  rsp1_result;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
    logic              alu_branch_op, alu_branch, busy;

    exp_t q0[$];
    exp_t q1[$];
    int   grant_log[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   w;
    exp_t alu_stub;

    always #5 clock = ~clock;

    alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b), .req0_branch_op(req0_branch_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_branch(rsp0_branch),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b), .req1_branch_op(req1_branch_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_branch(rsp1_branch),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_branch_op(alu_branch_op), .alu_result(alu_result),
        .alu_branch(alu_branch), .busy(busy)
    );

    // Reference ALU: used both as the stub behind the DUT and to predict responses
    function automatic exp_t alu_model(input logic [5:0] c, input logic [31:0] a,
                                       input logic [31:0] b, input logic bop);
        exp_t e;
        e.result = 32'd0;
        e.branch = 1'b0;
        case (c)
            OP_ADD: e.result = a + b;
            OP_SUB: e.result = a - b;
            OP_SLT: e.result = {31'd0, ($signed(a) < $signed(b))};
            OP_XOR: e.result = a ^ b;
            OP_SRA: e.result = $signed(a) >>> b[4:0];
            OP_BNE: begin
                e.result = {31'd0, (a != b)};
                e.branch = bop & (a != b);
            end
            OP_JAL: begin
                e.result = b + 32'd8;
                e.branch = bop;
            end
            default: e.result = 32'd0;
        endcase
        return e;
    endfunction

    assign alu_stub   = alu_model(alu_ctrl, alu_a, alu_b, alu_branch_op);
    assign alu_result = alu_stub.result;
    assign alu_branch = alu_stub.branch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Monitor: record accepts into the scoreboards, compare on response handshake
    always @(negedge clock) begin : monitor
        exp_t e;
        #2;
        if (!reset) begin
            check("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (req0_valid && req0_ready) begin
                q0.push_back(alu_model(req0_ctrl, req0_a, req0_b, req0_branch_op));
                grant_log.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                q1.push_back(alu_model(req1_ctrl, req1_a, req1_b, req1_branch_op));
                grant_log.push_back(1);
            end
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) begin
                    check("rsp0_unexpected", {31'd0, rsp0_valid}, 32'd0);
                end else begin
                    e = q0.pop_front();
                    check("sb_rsp0_result", rsp0_result, e.result);
                    check("sb_rsp0_branch", {31'd0, rsp0_branch}, {31'd0, e.branch});
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) begin
                    check("rsp1_unexpected", {31'd0, rsp1_valid}, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("sb_rsp1_result", rsp1_result, e.result);
                    check("sb_rsp1_branch", {31'd0, rsp1_branch}, {31'd0, e.branch});
                end
            end
        end
    end

    // Present a request at the current negedge, wait for its grant, drop valid
    // on the following negedge (the EXEC cycle) and return there.
    task automatic send(input int port, input logic [5:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic bop, output int waited);
        logic got;
        got    = 1'b0;
        waited = 0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_ctrl = c; req0_a = a; req0_b = b; req0_branch_op = bop;
        end else begin
            req1_valid = 1'b1; req1_ctrl = c; req1_a = a; req1_b = b; req1_branch_op = bop;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
            waited++;
        end
        check((port == 0) ? "send0_grant" : "send1_grant", {31'd0, got}, 32'd1);
        @(negedge clock);
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    // Wait (bounded) until the port's response is valid; returns 1 after that negedge
    task automatic wait_rsp(input int port);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((port == 0 && rsp0_valid) || (port == 1 && rsp1_valid)) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check((port == 0) ? "wait_rsp0" : "wait_rsp1", {31'd0, got}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        reset = 1'b1;
        req0_valid = 1'b0; req0_ctrl = 6'd0; req0_a = 32'd0; req0_b = 32'd0; req0_branch_op = 1'b0;
        req1_valid = 1'b0; req1_ctrl = 6'd0; req1_a = 32'd0; req1_b = 32'd0; req1_branch_op = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {26'd0, rsp0_valid, rsp1_valid, rsp0_branch, rsp1_branch,
                            req0_ready, req1_ready}, 32'd0);
        check("rst_rsp0_result", rsp0_result, 32'd0);
        check("rst_rsp1_result", rsp1_result, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_ctrl", {25'd0, alu_branch_op, alu_ctrl}, 32'd0);
        req0_valid = 1'b1;
        #1;
        check("rst_no_grant", {31'd0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Single add on port 0
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        send(0, OP_ADD, 32'd4, 32'd5, 1'b0, w);
        check("t1_first_cycle_grant", w, 32'd0);
        #1;
        check("t1_busy_exec", {31'd0, busy}, 32'd1);
        check("t1_rsp0_not_yet", {31'd0, rsp0_valid}, 32'd0);
        check("t1_alu_a", alu_a, 32'd4);
        check("t1_alu_b", alu_b, 32'd5);
        check("t1_alu_ctrl", {26'd0, alu_ctrl}, {26'd0, OP_ADD});
        @(negedge clock); #1;
        check("t1_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check("t1_rsp0_result", rsp0_result, 32'd9);
        check("t1_rsp1_quiet", {31'd0, rsp1_valid}, 32'd0);
        @(negedge clock); #1;
        check("t1_rsp0_drop", {31'd0, rsp0_valid}, 32'd0);
        check("t1_busy_idle", {31'd0, busy}, 32'd0);
        check("t1_alu_hold", alu_a, 32'd4);
        @(negedge clock);

        // Simultaneous requests right after reset: port 0 wins, port 1 next
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        req0_valid = 1'b1; req0_ctrl = OP_SUB; req0_a = 32'd4; req0_b = 32'd5; req0_branch_op = 1'b0;
        req1_valid = 1'b1; req1_ctrl = OP_SLT; req1_a = 32'd4; req1_b = 32'd5; req1_branch_op = 1'b0;
        #1;
        check("t2_ready0", {31'd0, req0_ready}, 32'd1);
        check("t2_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clock);
        req0_valid = 1'b0;
        got = 1'b0;
        w = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i == 1) check("t2_rsp0_result", rsp0_result, 32'hFFFF_FFFF);
            if (req1_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
            w++;
        end
        check("t2_port1_granted", {31'd0, got}, 32'd1);
        check("t2_accept_gap", w, 32'd3);
        @(negedge clock);
        req1_valid = 1'b0;
        wait_rsp(1);
        check("t2_rsp1_result", rsp1_result, 32'd1);
        check("t2_rsp0_quiet", {31'd0, rsp0_valid}, 32'd0);
        repeat (2) @(negedge clock);

        // Both ports held valid: grants alternate
        grant_log.delete();
        req0_valid = 1'b1; req0_ctrl = OP_XOR; req0_a = 32'h35; req0_b = 32'h26; req0_branch_op = 1'b0;
        req1_valid = 1'b1; req1_ctrl = OP_SUB; req1_a = 32'd100; req1_b = 32'd1; req1_branch_op = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (i == 2) check("t3_xor_result", rsp0_result, 32'h13);
            if (grant_log.size() >= 4) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t3_four_grants", {31'd0, got}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check("t3_grant_order", grant_log[i], i % 2);
        end
        repeat (4) @(negedge clock);
        #1;
        check("t3_drained_busy", {31'd0, busy}, 32'd0);
        check("t3_sb_empty", q0.size() + q1.size(), 32'd0);
        @(negedge clock);

        // Backpressure on port 1 while port 0 waits
        rsp1_ready = 1'b0;
        send(1, OP_BNE, 32'd4, 32'd3, 1'b1, w);
        req0_valid = 1'b1; req0_ctrl = OP_ADD; req0_a = 32'd1; req0_b = 32'd2; req0_branch_op = 1'b0;
        wait_rsp(1);
        for (int i = 0; i < 3; i++) begin
            check("t4_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
            check("t4_rsp1_result", rsp1_result, 32'd1);
            check("t4_rsp1_branch", {31'd0, rsp1_branch}, 32'd1);
            check("t4_req0_blocked", {31'd0, req0_ready}, 32'd0);
            @(negedge clock); #1;
        end
        rsp1_ready = 1'b1;
        rsp0_ready = 1'b1;
        @(negedge clock); #1;
        check("t4_rsp1_clear", {31'd0, rsp1_valid}, 32'd0);
        check("t4_req0_grant", {31'd0, req0_ready}, 32'd1);
        @(negedge clock);
        req0_valid = 1'b0;
        wait_rsp(0);
        check("t4_rsp0_result", rsp0_result, 32'd3);
        @(negedge clock);

        // Reset during EXEC discards the operation
        send(0, OP_SRA, 32'hFFFF_FF80, 32'd1, 1'b0, w);
        reset = 1'b1;
        @(negedge clock); #1;
        check("t5_rsp0_dropped", {31'd0, rsp0_valid}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_alu_a", alu_a, 32'd0);
        check("t5_alu_b", alu_b, 32'd0);
        check("t5_alu_ctrl", {26'd0, alu_ctrl}, 32'd0);
        q0.delete();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check("t5_no_rsp0", {31'd0, rsp0_valid}, 32'd0);
        end
        @(negedge clock);
        send(0, OP_SRA, 32'hFFFF_FF80, 32'd1, 1'b0, w);
        wait_rsp(0);
        check("t5_sra_result", rsp0_result, 32'hFFFF_FFC0);
        @(negedge clock);
        @(negedge clock);

        // jal pass-through and busy window with one cycle of response stall
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_ctrl = OP_JAL; req0_a = 32'hFFFF_FFFC; req0_b = 32'hFFFF_FFFD;
        req0_branch_op = 1'b1;
        #1;
        check("t6_busy_T", {31'd0, busy}, 32'd0);
        check("t6_ready_T", {31'd0, req0_ready}, 32'd1);
        @(negedge clock);
        req0_valid = 1'b0;
        #1;
        check("t6_busy_T1", {31'd0, busy}, 32'd1);
        @(negedge clock); #1;
        check("t6_busy_T2", {31'd0, busy}, 32'd1);
        check("t6_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check("t6_rsp0_result", rsp0_result, 32'd5);
        check("t6_rsp0_branch", {31'd0, rsp0_branch}, 32'd1);
        @(negedge clock); #1;
        check("t6_busy_T3", {31'd0, busy}, 32'd1);
        rsp0_ready = 1'b1;
        @(negedge clock); #1;
        check("t6_busy_T4", {31'd0, busy}, 32'd0);
        check("t6_rsp0_clear", {31'd0, rsp0_valid}, 32'd0);
        @(negedge clock); #1;
        check("end_sb_empty", q0.size() + q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
